// File: rtl/mux16_sched_pkg.sv
// mux16_sched_pkg: shared types and helpers for the 16:1 mux read scheduler.
//   state_e : scheduler FSM states (IDLE, SETTLE, SAMPLE)
//   NREQ    : number of requesters / mux inputs
//   SEL_W   : width of the mux select
//   onehot  : select index -> one-hot acknowledge vector
package mux16_sched_pkg;
  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/mux16_sched_if.sv
// mux16_sched_if: requester and mux-side signals of the scheduler.
//   req/sched_en     : requester side into the scheduler
//   ack/rdata/busy   : scheduler back to the requesters
//   mux_sel/mux_dis  : scheduler drives the shared mux
//   mux_out          : mux output bit into the scheduler
// master = requesters + mux (environment), slave = scheduler.
interface mux16_sched_if;
  import mux16_sched_pkg::*;

  logic [NREQ-1:0]  req;
  logic             sched_en;
  logic [NREQ-1:0]  ack;
  logic             rdata;
  logic             busy;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_dis;
  logic             mux_out;

  modport master (output req, sched_en, mux_out,
                  input  ack, rdata, busy, mux_sel, mux_dis);
  modport slave  (input  req, sched_en, mux_out,
                  output ack, rdata, busy, mux_sel, mux_dis);
endinterface

// File: rtl/mux16_sched_rr_pick16.sv
// rr_pick16: combinational round-robin picker.
//   req[15:0] : pending requests
//   ptr[3:0]  : highest-priority index this round
//   grant     : first set req bit at or above ptr, wrapping 15 -> 0
//   any_req   : at least one request pending (grant is only meaningful then)
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_req
);
  always_comb begin
    grant   = ptr;
    any_req = |req;
    // Scan from the farthest offset down so the nearest set bit wins last.
    // The 4-bit add gives the wrap for free.
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) grant = ptr + SEL_W'(k);
    end
  end
endmodule

// File: rtl/mux16_sched.sv
// mux16_sched: round-robin owner of a shared 16:1 data-select mux.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux16_sched_if.slave (req, sched_en, mux_out in;
//                ack, rdata, busy, mux_sel, mux_dis out)
// Parameter SETTLE_CYC (1..15): cycles the selected input settles before
// it is sampled.
// Build option MUX16_SCHED_SYNC_EN: mux_out goes through a two-flop
// synchronizer and the settle window grows by two cycles to cover it.
module mux16_sched
  import mux16_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux16_sched_if.slave bus
);
`ifdef MUX16_SCHED_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYC + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYC;
`endif
  localparam logic [4:0] CNT_LOAD = 5'(SETTLE_LEN);

  state_e           state, state_nxt;
  logic [SEL_W-1:0] ptr, sel, win;
  logic [4:0]       cnt;
  logic             dis, rd, any_req, start, samp_bit;
  logic [NREQ-1:0]  ack;

  rr_pick16 u_pick (.req(bus.req), .ptr(ptr), .grant(win), .any_req(any_req));

`ifdef MUX16_SCHED_SYNC_EN
  // Reset to 1 to match what a disabled mux drives.
  logic sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.mux_out;
      sync2 <= sync1;
    end
  end
  assign samp_bit = sync2;
`else
  assign samp_bit = bus.mux_out;
`endif

  assign start = (state == IDLE) && bus.sched_en && any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = SETTLE;
      SETTLE:  if (cnt == 5'd1) state_nxt = SAMPLE;
      SAMPLE:                  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Datapath. ack is a single-cycle pulse: cleared every edge unless SAMPLE.
  // sel is only loaded at a grant, so the winner is frozen against req changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      sel <= '0;
      dis <= 1'b1;
      ack <= '0;
      rd  <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: if (start) begin
          sel <= win;
          dis <= 1'b0;
          cnt <= CNT_LOAD;
        end
        SETTLE: cnt <= cnt - 5'd1;
        SAMPLE: begin
          rd  <= samp_bit;
          ack <= onehot(sel);
          dis <= 1'b1;
          ptr <= sel + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mux_sel = sel;
  assign bus.mux_dis = dis;
  assign bus.ack     = ack;
  assign bus.rdata   = rd;
  assign bus.busy    = (state != IDLE);
endmodule
